hack_alu_pipe: RTL
==================

# hack_alu_pipe

Two-stage, valid/ready-handshaked Hack ALU stage that directly consumes the 16-bit bitwise-inverter stage. It applies the six Hack control bits (zx, nx, zy, ny, f, no) to operands x and y, and registers the result together with the zr/ng flags. It sits between the CPU decode/operand-select logic and the D/A/M writeback path. Backpressure from writeback stalls the pipeline without loss.

## Interface
Parameters:
- WIDTH, 16, datapath width; the Hack ISA fixes it at 16, and the test plan assumes 16.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  x, y and ctrl are valid this cycle.
- in_ready  out  1  stage 1 accepts this cycle.
- x  in  WIDTH  operand x (D register).
- y  in  WIDTH  operand y (A or M).
- ctrl  in  6  {zx,nx,zy,ny,f,no}; zx is the MSB.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  WIDTH  ALU result.
- zr  out  1  set when out == 0.
- ng  out  1  equals out[WIDTH-1].
- ov  out  1  signed add overflow; present only with HACK_ALU_OVF_EN.

## Operation
- Stage 1 (preset), evaluated on accept:
  - xp = zx ? 0 : x; then xp = nx ? ~xp : xp.
  - yp = zy ? 0 : y; then yp = ny ? ~yp : yp.
  - Bitwise inversion uses the codebase's 16-bit inverter instances.
  - Registers: s1_valid, xp, yp, f, no.
- Stage 2 (function), evaluated on advance:
  - r = f ? (xp + yp) mod 2^WIDTH : (xp & yp); carry-out is discarded.
  - out = no ? ~r : r; zr and ng are computed from the final out.
  - Registers: s2_valid (drives out_valid), out, zr, ng, ov.
- Flow control:
  - s2_take = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_take.
  - in_ready = !s1_valid || s2_take.
  - Accept happens when in_valid && in_ready.
- Every cycle:
  - s2_valid <= s1_adv || (s2_valid && !out_ready).
  - s1_valid <= accept || (s1_valid && !s2_take).
- Data registers load only on accept (stage 1) or s1_adv (stage 2). Otherwise they hold their value.
- Simultaneous accept, advance and consume in one cycle is legal and sustains 1 result/cycle.
- While out_valid=1 and out_ready=0, out, zr, ng and ov hold stable.
- in_ready depends combinationally on out_ready only; there is no combinational path from in_valid to out_valid.

## Timing
- Reset values: s1_valid=0, out_valid=0, out=0, zr=0, ng=0, ov=0. in_ready reads 1 while reset is deasserted and the pipe is empty.
- Reset assertion clears all registers immediately (asynchronous), including mid-stall. Any in-flight results are dropped.
- Latency: a transaction accepted at edge N presents out_valid=1 after edge N+1, provided there is no stall.
- Throughput: 1 transaction/cycle.
- Capacity: 2 transactions. With out_ready held low, in_ready falls after the second accept.
- Ordering is strictly in-order; results are never duplicated or lost.

## Configuration
- HACK_ALU_OVF_EN defined:
  - Port ov exists and is registered in stage 2.
  - ov = f && (xp[MSB]==yp[MSB]) && (sum[MSB]!=xp[MSB]), computed before the no inversion.
  - ov is 0 when f=0.
- HACK_ALU_OVF_EN undefined:
  - Port ov and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out=0x0000, zr=0, ng=0. After release: in_ready=1, and the first result appears 2 cycles after accept.
- Add: x=0x0005, y=0x0003, ctrl=000010 -> out=0x0008, zr=0, ng=0, out_valid 2 cycles after accept.
- Constants and x-1:
  - ctrl=101010 -> out=0x0000, zr=1.
  - ctrl=111010 -> out=0xFFFF, ng=1.
  - x=0x0005, ctrl=001110 -> out=0x0004.
- Backpressure: out_ready=0, offer 3 back-to-back ops.
  - Required: only 2 accepted; in_ready=0 on the third cycle.
  - Raise out_ready: the 3 results emerge in order, each exactly once, then the pipe is empty.
- Overflow (HACK_ALU_OVF_EN): x=0x7FFF, y=0x0001, ctrl=000010 -> out=0x8000, ng=1, ov=1. ctrl=000000 on the same operands -> ov=0.
- Mid-operation reset: both stages full and stalled, pulse rst_n low for half a cycle -> out_valid drops to 0 before the next edge. No stale result appears after release.

Source files
------------

// File: rtl/hack_alu_pipe.sv
// Two-stage valid/ready Hack ALU: stage 1 applies zx/nx/zy/ny presets, stage 2 the f/no function.
// Define HACK_ALU_OVF_EN to add the registered signed-add overflow flag (port ov).

module hack_not16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    assign y = ~a;
endmodule

module hack_alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
`ifdef HACK_ALU_OVF_EN
    ,
    output logic             ov
`endif
);

    logic             zx, nx, zy, ny, f_in, no_in;
    logic             s2_take, s1_adv, accept;

    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH-1:0] xp_q, yp_q;
    logic             f_q, no_q;
    logic [WIDTH-1:0] out_q;
    logic             zr_q, ng_q;

    logic [WIDTH-1:0] x_z, x_inv, xp_d;
    logic [WIDTH-1:0] y_z, y_inv, yp_d;
    logic [WIDTH-1:0] sum, r, r_inv, out_d;
    logic             zr_d, ng_d;

    assign {zx, nx, zy, ny, f_in, no_in} = ctrl;

    // in_ready looks only at pipe state and out_ready, never at in_valid.
    assign s2_take  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_take;
    assign in_ready = !s1_valid_q || s2_take;
    assign accept   = in_valid && in_ready;

    hack_not16 #(.WIDTH(WIDTH)) u_not_x (.a(x_z), .y(x_inv));
    hack_not16 #(.WIDTH(WIDTH)) u_not_y (.a(y_z), .y(y_inv));
    hack_not16 #(.WIDTH(WIDTH)) u_not_r (.a(r),   .y(r_inv));

    always_comb begin
        x_z  = zx ? '0 : x;
        xp_d = nx ? x_inv : x_z;
        y_z  = zy ? '0 : y;
        yp_d = ny ? y_inv : y_z;
    end

    always_comb begin
        sum   = xp_q + yp_q;
        r     = f_q ? sum : (xp_q & yp_q);
        out_d = no_q ? r_inv : r;
        zr_d  = (out_d == '0);
        ng_d  = out_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            xp_q       <= '0;
            yp_q       <= '0;
            f_q        <= 1'b0;
            no_q       <= 1'b0;
        end else begin
            s1_valid_q <= accept || (s1_valid_q && !s2_take);
            if (accept) begin
                xp_q <= xp_d;
                yp_q <= yp_d;
                f_q  <= f_in;
                no_q <= no_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            out_q      <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
        end else begin
            s2_valid_q <= s1_adv || (s2_valid_q && !out_ready);
            if (s1_adv) begin
                out_q <= out_d;
                zr_q  <= zr_d;
                ng_q  <= ng_d;
            end
        end
    end

`ifdef HACK_ALU_OVF_EN
    logic ov_d, ov_q;

    // Judged on the raw sum, before any no inversion.
    assign ov_d = f_q && (xp_q[WIDTH-1] == yp_q[WIDTH-1]) && (sum[WIDTH-1] != xp_q[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
        end else if (s1_adv) begin
            ov_q <= ov_d;
        end
    end

    assign ov = ov_q;
`endif

    assign out_valid = s2_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

endmodule
